// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default latencies,
// FSM state type, 64-bit result type and op-class decode helpers.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU acceptance).
package mdu_pkg;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;

    typedef logic [63:0] dword_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Multiply-class ops use MULT_CYCLES latency. MADD/MADDU only join this
    // class when the accumulate feature is built in; otherwise they fall
    // through to the no-op path like any other unused code.
    function automatic logic is_mul_op(input logic [3:0] op);
        logic r;
        r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
        r = r || (op == OP_MADD) || (op == OP_MADDU);
`endif
        return r;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath for the MDU: signed/unsigned product, quotient,
// remainder and HI/LO accumulate, selected by op. Result is {hi, lo}.
// Ports: op, rs_data, rt_data, hi_in/lo_in (accumulate base) -> result, div_zero.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    output dword_t      result,
    output logic        div_zero
);

    logic signed [63:0] s_prod;
    logic        [63:0] u_prod;
    logic signed [31:0] s_dividend;
    logic signed [31:0] s_divisor;
    logic signed [31:0] s_quot;
    logic signed [31:0] s_rem;
    logic        [31:0] u_divisor;
    logic        [31:0] u_quot;
    logic        [31:0] u_rem;
    logic               s_ovf;

    // 64x64 products truncated to 64 bits equal the exact 32x32 products.
    assign s_prod = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    assign u_prod = {32'd0, rs_data} * {32'd0, rt_data};

    assign div_zero = (rt_data == 32'd0);

    // The only signed overflow case (most-negative / -1) is steered to a
    // divide by +1, which yields quotient 0x80000000 and remainder 0.
    // A zero divisor is likewise replaced so the divider never sees 0; the
    // result is discarded upstream in that case anyway.
    assign s_ovf      = (rs_data == 32'h8000_0000) && (rt_data == 32'hFFFF_FFFF);
    assign s_dividend = rs_data;
    assign s_divisor  = (div_zero || s_ovf) ? 32'sd1 : rt_data;
    assign u_divisor  = div_zero ? 32'd1 : rt_data;

    // Verilog signed / and % truncate toward zero; remainder follows dividend.
    assign s_quot = s_dividend / s_divisor;
    assign s_rem  = s_dividend % s_divisor;
    assign u_quot = rs_data / u_divisor;
    assign u_rem  = rs_data % u_divisor;

    always_comb begin
        result = '0;
        case (op)
            OP_MULT:  result = s_prod;
            OP_MULTU: result = u_prod;
            OP_DIV:   result = {s_rem, s_quot};
            OP_DIVU:  result = {u_rem, u_quot};
            OP_MADD:  result = {hi_in, lo_in} + s_prod;
            OP_MADDU: result = {hi_in, lo_in} + u_prod;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit owning architectural HI/LO. Results are computed
// at issue, held pending, and committed to HI/LO when the busy counter expires.
// Ports: clk, reset (async active-low), start/op/rs_data/rt_data in; busy, hi_out, lo_out out.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU accumulate into HI/LO).
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dword_t            pend_q, pend_d;
    logic              pend_wr_q, pend_wr_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;

    dword_t            arith_res;
    logic              arith_div_zero;

    mdu_arith u_arith (
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .hi_in    (hi_q),
        .lo_in    (lo_q),
        .result   (arith_res),
        .div_zero (arith_div_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_mul_op(op)) begin
                        pend_d    = arith_res;
                        pend_wr_d = 1'b1;
                        cnt_d     = CNT_W'(MULT_CYCLES);
                        state_d   = ST_RUN;
                    end else if (is_div_op(op)) begin
                        // Divide by zero still occupies the unit but must
                        // leave HI/LO untouched at completion.
                        pend_d    = arith_res;
                        pend_wr_d = !arith_div_zero;
                        cnt_d     = CNT_W'(DIV_CYCLES);
                        state_d   = ST_RUN;
                    end else if (op == OP_MTHI) begin
                        hi_d = rs_data;
                    end else if (op == OP_MTLO) begin
                        lo_d = rs_data;
                    end
                end
            end
            ST_RUN: begin
                // start is deliberately ignored here; the hazard unit holds
                // MDU ops in D while busy.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = ST_IDLE;
                    pend_wr_d = 1'b0;
                    if (pend_wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy   = (state_q == ST_RUN);
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
module tb_mdu_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int vecs;
    int errs;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi_out  (hi_out),
        .lo_out  (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one start pulse; returns at the negedge following the issue edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start   = 1'b0;
        op      = 4'd0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        op = 4'd0;
        rs_data = 32'd0;
        rt_data = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
        vecs++; if (hi_out !== 32'h0) begin errs++; $display("FAIL reset_hi got %h want 00000000", hi_out); end
        vecs++; if (lo_out !== 32'h0) begin errs++; $display("FAIL reset_lo got %h want 00000000", lo_out); end
    endtask

    task automatic test_mult(input string nm, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] pre_hi, input logic [31:0] pre_lo,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(o, a, b);
        for (int k = 0; k < 5; k++) begin
            vecs++;
            if (busy !== 1'b1 || hi_out !== pre_hi || lo_out !== pre_lo) begin
                errs++;
                $display("FAIL %s_run k=%0d got busy=%b hi=%h lo=%h want busy=1 hi=%h lo=%h",
                         nm, k, busy, hi_out, lo_out, pre_hi, pre_lo);
            end
            @(negedge clk);
        end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL %s_done_busy got %b want 0", nm, busy); end
        vecs++; if (hi_out !== exp_hi) begin errs++; $display("FAIL %s_hi got %h want %h", nm, hi_out, exp_hi); end
        vecs++; if (lo_out !== exp_lo) begin errs++; $display("FAIL %s_lo got %h want %h", nm, lo_out, exp_lo); end
    endtask

    task automatic test_div(input string nm, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pre_hi, input logic [31:0] pre_lo,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(o, a, b);
        for (int k = 0; k < 10; k++) begin
            vecs++;
            if (busy !== 1'b1 || hi_out !== pre_hi || lo_out !== pre_lo) begin
                errs++;
                $display("FAIL %s_run k=%0d got busy=%b hi=%h lo=%h want busy=1 hi=%h lo=%h",
                         nm, k, busy, hi_out, lo_out, pre_hi, pre_lo);
            end
            @(negedge clk);
        end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL %s_done_busy got %b want 0", nm, busy); end
        vecs++; if (hi_out !== exp_hi) begin errs++; $display("FAIL %s_hi got %h want %h", nm, hi_out, exp_hi); end
        vecs++; if (lo_out !== exp_lo) begin errs++; $display("FAIL %s_lo got %h want %h", nm, lo_out, exp_lo); end
    endtask

    task automatic test_mthi_mtlo;
        issue(4'd5, 32'h1234_5678, 32'hDEAD_BEEF);
        vecs++; if (hi_out !== 32'h1234_5678) begin errs++; $display("FAIL mthi_hi got %h want 12345678", hi_out); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mthi_busy got %b want 0", busy); end
        issue(4'd6, 32'h9ABC_DEF0, 32'h0);
        vecs++; if (lo_out !== 32'h9ABC_DEF0) begin errs++; $display("FAIL mtlo_lo got %h want 9abcdef0", lo_out); end
        vecs++; if (hi_out !== 32'h1234_5678) begin errs++; $display("FAIL mtlo_hi_kept got %h want 12345678", hi_out); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mtlo_busy got %b want 0", busy); end
    endtask

    // DIV 100/7 in flight; a MULTU 2x3 attempt mid-run must be ignored.
    task automatic test_ignore_while_busy;
        issue(4'd6, 32'h1111_1111, 32'h0);
        issue(4'd5, 32'h2222_2222, 32'h0);
        issue(4'd3, 32'd100, 32'd7);
        for (int k = 0; k < 10; k++) begin
            vecs++;
            if (busy !== 1'b1 || hi_out !== 32'h2222_2222 || lo_out !== 32'h1111_1111) begin
                errs++;
                $display("FAIL ignore_run k=%0d got busy=%b hi=%h lo=%h want busy=1 hi=22222222 lo=11111111",
                         k, busy, hi_out, lo_out);
            end
            start = (k == 3);
            op = (k == 3) ? 4'd2 : 4'd0;
            rs_data = 32'd2;
            rt_data = 32'd3;
            @(negedge clk);
            start = 1'b0;
            op = 4'd0;
        end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL ignore_done_busy got %b want 0", busy); end
        vecs++; if (hi_out !== 32'd2) begin errs++; $display("FAIL ignore_hi got %h want 00000002", hi_out); end
        vecs++; if (lo_out !== 32'd14) begin errs++; $display("FAIL ignore_lo got %h want 0000000e", lo_out); end
        repeat (6) @(negedge clk);
        vecs++;
        if (busy !== 1'b0 || hi_out !== 32'd2 || lo_out !== 32'd14) begin
            errs++;
            $display("FAIL ignore_late got busy=%b hi=%h lo=%h want busy=0 hi=00000002 lo=0000000e", busy, hi_out, lo_out);
        end
    endtask

    task automatic test_undefined_ops;
        logic [3:0] codes [3];
        codes[0] = 4'd0;
        codes[1] = 4'd9;
        codes[2] = 4'd15;
        for (int i = 0; i < 3; i++) begin
            issue(codes[i], 32'h5555_5555, 32'd3);
            @(negedge clk);
            vecs++;
            if (busy !== 1'b0 || hi_out !== 32'd2 || lo_out !== 32'd14) begin
                errs++;
                $display("FAIL undef_op%0d got busy=%b hi=%h lo=%h want busy=0 hi=00000002 lo=0000000e",
                         codes[i], busy, hi_out, lo_out);
            end
        end
    endtask

    task automatic test_madd;
        issue(4'd5, 32'h0, 32'h0);
        issue(4'd6, 32'hFFFF_FFFF, 32'h0);
`ifdef MDU_MADD_EN
        test_mult("maddu", 4'd8, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0);
        test_mult("madd", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'h1, 32'h0, 32'h0, 32'hFFFF_FFFF);
`else
        issue(4'd8, 32'd1, 32'd1);
        for (int k = 0; k < 6; k++) begin
            vecs++;
            if (busy !== 1'b0 || hi_out !== 32'h0 || lo_out !== 32'hFFFF_FFFF) begin
                errs++;
                $display("FAIL maddu_off k=%0d got busy=%b hi=%h lo=%h want busy=0 hi=00000000 lo=ffffffff",
                         k, busy, hi_out, lo_out);
            end
            @(negedge clk);
        end
        issue(4'd7, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        vecs++;
        if (busy !== 1'b0 || hi_out !== 32'h0 || lo_out !== 32'hFFFF_FFFF) begin
            errs++;
            $display("FAIL madd_off got busy=%b hi=%h lo=%h want busy=0 hi=00000000 lo=ffffffff", busy, hi_out, lo_out);
        end
`endif
    endtask

    task automatic test_reset_mid_op;
        issue(4'd5, 32'hAAAA_5555, 32'h0);
        issue(4'd1, 32'd3, 32'd4);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy got %b want 0", busy); end
        vecs++; if (hi_out !== 32'h0) begin errs++; $display("FAIL rstmid_hi got %h want 00000000", hi_out); end
        vecs++; if (lo_out !== 32'h0) begin errs++; $display("FAIL rstmid_lo got %h want 00000000", lo_out); end
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        vecs++;
        if (busy !== 1'b0 || hi_out !== 32'h0 || lo_out !== 32'h0) begin
            errs++;
            $display("FAIL rstmid_after got busy=%b hi=%h lo=%h want busy=0 hi=00000000 lo=00000000", busy, hi_out, lo_out);
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_mult("mult_neg", 4'd1, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        test_mult("multu_max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
                  32'hFFFF_FFFE, 32'h0000_0001);
        test_mult("mult_max", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
                  32'h0, 32'h1);
        test_div("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        test_div("div_negdiv", 4'd3, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h1, 32'hFFFF_FFFD);
        test_div("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFD, 32'h0, 32'h8000_0000);
        test_div("divu", 4'd4, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h8000_0000, 32'h1, 32'h7FFF_FFFC);
        test_div("divu_zero", 4'd4, 32'd7, 32'd0, 32'h1, 32'h7FFF_FFFC, 32'h1, 32'h7FFF_FFFC);
        test_div("div_zero", 4'd3, 32'hFFFF_FFF9, 32'd0, 32'h1, 32'h7FFF_FFFC, 32'h1, 32'h7FFF_FFFC);
        test_mthi_mtlo();
        test_ignore_while_busy();
        test_undefined_ops();
        test_madd();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Multiply/divide unit for the five-stage MIPS core, sitting in the E stage beside the ALU and feeding the HI/LO values that MFHI/MFLO forward to the M stage. It accepts one MULT/MULTU/DIV/DIVU (optionally MADD/MADDU) per issue, models fixed multi-cycle latency with a busy counter, and owns the architectural HI/LO registers. The hazard unit uses `busy` to stall any MDU instruction held in D.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for multiply ops (≥1).
- `DIV_CYCLES`, default 10: busy cycles for divide ops (≥1).

- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset (asserted when 0).
- `start`  in  1: E-stage instruction is an MDU op; qualifies `op`.
- `op`  in  4: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU; others are no-op.
- `rs_data`  in  32: forwarded rs operand (dividend / multiplicand / MT source).
- `rt_data`  in  32: forwarded rt operand (divisor / multiplier).
- `busy`  out  1: operation in flight.
- `hi_out`  out  32: architectural HI register.
- `lo_out`  out  32: architectural LO register.

## Operation
- Reset (reset=0, any time including mid-operation): busy=0, counter=0, HI=LO=0, pending result discarded.
- States: IDLE (counter=0) and RUN (counter>0).
- IDLE, start=1, op∈{MULT,MULTU,MADD,MADDU}: compute product and latch into pending {ph,pl}; counter←MULT_CYCLES; busy=1 next cycle.
- IDLE, start=1, op∈{DIV,DIVU}: pending ph=remainder, pl=quotient; counter←DIV_CYCLES.
- IDLE, start=1, op=MTHI/MTLO: HI (or LO) ← rs_data at that edge; busy stays 0.
- RUN: counter decrements each edge; on the 1→0 edge HI←ph, LO←pl and busy falls.
- start=1 while busy=1: ignored entirely (hazard unit guarantees this never happens legally; bench checks no state change).
- Arithmetic: MULT signed 32×32→64, MULTU unsigned; {HI,LO}=product. DIV signed: quotient truncated toward zero, remainder takes dividend's sign; 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. DIVU unsigned.
- Divide by zero (rt_data=0): busy sequence runs normally, HI/LO left unchanged at completion.
- Undefined op codes with start=1: no effect.

## Timing
- Issue edge E0 samples start; busy=1 for cycles following E0 through edge E0+N (N=MULT_CYCLES or DIV_CYCLES); HI/LO update and busy=0 at edge E0+N.
- A new op may issue at edge E0+N+1 at earliest? No: it may issue at edge E0+N+… the first edge where busy was sampled 0, i.e. E0+N+1 relative issue is the earliest cycle D-stage stall releases; start at E0+N itself is ignored because busy=1 then.
- MTHI/MTLO: visible on hi_out/lo_out one cycle after the issue edge.
- hi_out/lo_out are register outputs; no combinational path from inputs.

## Configuration
- `MDU_MADD_EN` defined: op 7 MADD ({HI,LO}←{HI,LO}+signed product) and op 8 MADDU (unsigned product) accepted, MULT_CYCLES latency; accumulate uses HI/LO values at issue edge, 64-bit wrap-around.
- Undefined: ops 7 and 8 behave as undefined codes (no-op, busy stays 0).

## Structure
- Package `mdu_pkg`: op code localparams/enum, default MULT_CYCLES/DIV_CYCLES, 64-bit result type.
- Sub-module `mdu_arith`: purely combinational product/quotient/remainder/accumulate from op and operands; `mdu_unit` holds counter, pending regs, HI/LO.

## Test plan
- MULT rs=0xFFFFFFFE (−2), rt=3 → busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 → busy 10 cycles, HI/LO unchanged.
- MTHI rs=0x12345678 then MTLO rs=0x9ABCDEF0 → HI/LO updated one cycle each, busy never asserts.
- start=1 MULTU 2×3 during DIV in flight → ignored; HI/LO end with DIV result only.
- reset driven low 3 cycles into MULT → busy=0, HI=LO=0 immediately (asynchronously); no later update.
- With MDU_MADD_EN: HI/LO=0/0xFFFFFFFF, MADDU 1×1 → after 5 cycles HI=1, LO=0; without macro same stimulus → no change, busy stays 0.
